// File: rtl/mips_bus_pkg.sv
// Shared types and helpers for the MIPS bus access unit: access sizes, FSM states,
// channel ids and the alignment check used at request acceptance.
package mips_bus_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_RSVD = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StResp
    } state_e;

    typedef enum logic {
        ChData  = 1'b0,
        ChFetch = 1'b1
    } chan_e;

    // Reserved sizes are treated as misaligned so the FSM has a single error check.
    function automatic logic is_misaligned(input size_e size, input logic [1:0] off);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = off[0];
            SZ_WORD: bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mips_lane_steer.sv
// Combinational byte-lane steering: store replication/byteenable generation and
// load lane selection with sign/zero extension, optionally byte-swapped.
module mips_lane_steer
    import mips_bus_pkg::*;
#(
    parameter bit SWAP_BYTES = 1'b1
) (
    input  size_e       st_size,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_wdata,
    output logic [3:0]  st_be,
    output logic [31:0] st_bus_wdata,
    input  size_e       ld_size,
    input  logic [1:0]  ld_off,
    input  logic        ld_unsigned,
    input  logic [31:0] ld_bus_rdata,
    output logic [31:0] ld_data
);

    function automatic logic [31:0] bswap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    logic [3:0]  be_lin;
    logic [31:0] wdata_lin;
    logic [31:0] rdata_lin;
    logic [31:0] shifted;

    // Lanes are built little-endian first; swapping reverses the whole word at the bus.
    always_comb begin
        be_lin    = 4'b0000;
        wdata_lin = st_wdata;
        case (st_size)
            SZ_BYTE: begin
                be_lin    = 4'b0001 << st_off;
                wdata_lin = {4{st_wdata[7:0]}};
            end
            SZ_HALF: begin
                be_lin    = 4'b0011 << st_off;
                wdata_lin = {2{st_wdata[15:0]}};
            end
            SZ_WORD: be_lin = 4'b1111;
            default: be_lin = 4'b0000;
        endcase
        st_be        = SWAP_BYTES ? {be_lin[0], be_lin[1], be_lin[2], be_lin[3]} : be_lin;
        st_bus_wdata = SWAP_BYTES ? bswap(wdata_lin) : wdata_lin;
    end

    always_comb begin
        rdata_lin = SWAP_BYTES ? bswap(ld_bus_rdata) : ld_bus_rdata;
        shifted   = rdata_lin >> {ld_off, 3'b000};
        case (ld_size)
            SZ_BYTE: ld_data = {{24{shifted[7] & ~ld_unsigned}}, shifted[7:0]};
            SZ_HALF: ld_data = {{16{shifted[15] & ~ld_unsigned}}, shifted[15:0]};
            default: ld_data = rdata_lin;
        endcase
    end

endmodule

// File: rtl/mips_bus_access_unit.sv
// Two-channel (fetch/data) Avalon-MM master front-end: arbitration, one transfer at a
// time held across waitrequest, alignment trapping and a waitrequest watchdog.
module mips_bus_access_unit
    import mips_bus_pkg::*;
#(
    parameter bit          SWAP_BYTES = 1'b1,
    parameter bit          ARB_MODE   = 1'b0,
    parameter int unsigned TIMEOUT    = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic        if_valid,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [1:0]  d_size,
    input  logic        d_unsigned,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ready,
    output logic        d_valid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    input  logic        waitrequest,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic [31:0] readdata,
    output logic        busy
);

    state_e      state_q, state_d;
    chan_e       chan_q, chan_d, last_q, last_d;
    size_e       size_q, size_d;
    logic [1:0]  off_q, off_d;
    logic        uns_q, uns_d;
    logic [31:0] address_q, address_d, writedata_q, writedata_d, rdata_q, rdata_d;
    logic        read_q, read_d, write_q, write_d, err_q, err_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wd_cnt_q, wd_cnt_d;

    logic        gnt_d, gnt_f;
    size_e       in_size;
    logic [31:0] in_addr, in_wdata, st_wdata, ld_data;
    logic        in_we, in_uns;
    logic [3:0]  st_be;

    always_comb begin
        gnt_d = 1'b0;
        gnt_f = 1'b0;
        if (state_q == StIdle && !reset) begin
            if (d_req && if_req) begin
                gnt_d = ARB_MODE ? (last_q == ChFetch) : 1'b1;
                gnt_f = !gnt_d;
            end else begin
                gnt_d = d_req;
                gnt_f = if_req;
            end
        end
    end

    // Fetches are forced to unextended word loads.
    always_comb begin
        in_size  = size_e'(d_size);
        in_addr  = d_addr;
        in_wdata = d_wdata;
        in_we    = d_we;
        in_uns   = d_unsigned;
        if (gnt_f) begin
            in_size  = SZ_WORD;
            in_addr  = if_addr;
            in_wdata = 32'd0;
            in_we    = 1'b0;
            in_uns   = 1'b1;
        end
    end

    mips_lane_steer #(
        .SWAP_BYTES(SWAP_BYTES)
    ) u_steer (
        .st_size     (in_size),
        .st_off      (in_addr[1:0]),
        .st_wdata    (in_wdata),
        .st_be       (st_be),
        .st_bus_wdata(st_wdata),
        .ld_size     (size_q),
        .ld_off      (off_q),
        .ld_unsigned (uns_q),
        .ld_bus_rdata(readdata),
        .ld_data     (ld_data)
    );

    always_comb begin
        state_d     = state_q;
        chan_d      = chan_q;
        last_d      = last_q;
        size_d      = size_q;
        off_d       = off_q;
        uns_d       = uns_q;
        address_d   = address_q;
        writedata_d = writedata_q;
        be_d        = be_q;
        read_d      = read_q;
        write_d     = write_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        wd_cnt_d    = wd_cnt_q;
        case (state_q)
            StIdle: begin
                if (gnt_d || gnt_f) begin
                    chan_d   = gnt_f ? ChFetch : ChData;
                    last_d   = chan_d;
                    size_d   = in_size;
                    off_d    = in_addr[1:0];
                    uns_d    = in_uns;
                    wd_cnt_d = 32'd0;
                    if (is_misaligned(in_size, in_addr[1:0])) begin
                        state_d = StResp;
                        err_d   = 1'b1;
                        rdata_d = 32'd0;
                    end else begin
                        state_d     = StAccess;
                        err_d       = 1'b0;
                        address_d   = {in_addr[31:2], 2'b00};
                        read_d      = !in_we;
                        write_d     = in_we;
                        writedata_d = st_wdata;
                        be_d        = st_be;
                    end
                end
            end
            StAccess: begin
                if (!waitrequest) begin
                    state_d = StResp;
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    err_d   = 1'b0;
                    rdata_d = write_q ? 32'd0 : ld_data;
                end else if (TIMEOUT != 0 && wd_cnt_q == 32'(TIMEOUT) - 32'd1) begin
                    state_d = StResp;
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    err_d   = 1'b1;
                    rdata_d = 32'd0;
                end else begin
                    wd_cnt_d = wd_cnt_q + 32'd1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            chan_q      <= ChData;
            last_q      <= ChFetch;
            size_q      <= SZ_BYTE;
            off_q       <= 2'b00;
            uns_q       <= 1'b0;
            address_q   <= 32'd0;
            writedata_q <= 32'd0;
            be_q        <= 4'b0000;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            rdata_q     <= 32'd0;
            err_q       <= 1'b0;
            wd_cnt_q    <= 32'd0;
        end else begin
            state_q     <= state_d;
            chan_q      <= chan_d;
            last_q      <= last_d;
            size_q      <= size_d;
            off_q       <= off_d;
            uns_q       <= uns_d;
            address_q   <= address_d;
            writedata_q <= writedata_d;
            be_q        <= be_d;
            read_q      <= read_d;
            write_q     <= write_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            wd_cnt_q    <= wd_cnt_d;
        end
    end

    // Gating by reset keeps a response in flight from leaking out during reset.
    assign if_ready   = gnt_f;
    assign d_ready    = gnt_d;
    assign if_valid   = !reset && state_q == StResp && chan_q == ChFetch;
    assign d_valid    = !reset && state_q == StResp && chan_q == ChData;
    assign if_rdata   = rdata_q;
    assign d_rdata    = rdata_q;
    assign if_err     = err_q;
    assign d_err      = err_q;
    assign address    = address_q;
    assign read       = read_q;
    assign write      = write_q;
    assign writedata  = writedata_q;
    assign byteenable = be_q;
    assign busy       = !reset && state_q != StIdle;

endmodule

// File: doc/mips_bus_access_unit.md
Name: mips_bus_access_unit

Overview:
- Two-channel Avalon-MM master front-end for the multicycle MIPS core: an instruction-fetch channel and a data load/store channel.
- Arbitrates between the channels and runs one bus transfer at a time, holding each transfer across waitrequest.
- Performs sub-word byte-lane steering, optional byte swap, sign/zero extension, misalignment trapping and a waitrequest watchdog.
- Sits between the core's control FSM and the external memory bus, replacing ad-hoc byteenable/endian glue in the top level.

Parameters:
- SWAP_BYTES, 1, 1: byte offset k maps to bus lane 3-k; 0: offset k maps to lane k.
- ARB_MODE, 0, 0: data channel has fixed priority; 1: round-robin when both channels request in the same IDLE cycle.
- TIMEOUT, 0, waitrequest watchdog limit in cycles; 0 disables the watchdog.

Ports:
- clk in 1: clock.
- reset in 1: reset, synchronous, active-high.
- if_req in 1: fetch request.
- if_addr in 32: fetch byte address.
- if_ready out 1: fetch request accepted this cycle.
- if_valid out 1: fetch response pulse.
- if_rdata out 32: fetched word.
- if_err out 1: fetch error, qualified by if_valid.
- d_req in 1: data request.
- d_we in 1: 1 = store, 0 = load.
- d_size in 2: 0 = byte, 1 = half, 2 = word, 3 = reserved.
- d_unsigned in 1: zero-extend loads when 1.
- d_addr in 32: data byte address.
- d_wdata in 32: store data, right-justified.
- d_ready out 1: data request accepted this cycle.
- d_valid out 1: data response pulse.
- d_rdata out 32: extended load result.
- d_err out 1: data error, qualified by d_valid.
- address out 32: bus address, always word-aligned.
- read out 1: Avalon read.
- write out 1: Avalon write.
- waitrequest in 1: Avalon waitrequest.
- writedata out 32: Avalon write data.
- byteenable out 4: Avalon byte enables.
- readdata in 32: Avalon read data.
- busy out 1: unit is not in IDLE.

Behaviour:
- Reset: every output is 0, state is IDLE, the round-robin pointer favours data, and the watchdog counter is cleared.
- Reset mid-transfer: read/write drop at the next edge and no valid pulse is ever issued for the aborted request.
- FSM states: IDLE, ACCESS, RESP.
- IDLE acceptance: when any request is present, exactly one is accepted by pulsing if_ready or d_ready combinationally in the same cycle.
- IDLE latching: the accepted request's address, size, we, unsigned, wdata and channel id are latched.
- Arbitration, ARB_MODE=0: data wins.
- Arbitration, ARB_MODE=1: the channel opposite the last granted one wins, but only when both channels request.
- IDLE, aligned request: next state is ACCESS.
- IDLE, misaligned or reserved request: next state is RESP with err=1 and no bus cycle.
  - Misaligned means half with addr[0]=1, or word with addr[1:0]!=0.
  - Reserved means d_size=3.
- Fetch requests are always word size, loaded, with no extension.
- ACCESS, bus outputs (registered): address = addr & 0xFFFFFFFC; read = !we, write = we.
- ACCESS, byteenable: 1 lane for byte, 2 lanes for half, 4'b1111 for word, mapped through SWAP_BYTES.
- ACCESS, writedata: byte replicated to all 4 lanes, half replicated to both halves, word passed through; when SWAP_BYTES=1 the full word is byte-reversed.
- ACCESS hold: address, read, write, writedata and byteenable stay constant while waitrequest=1.
- ACCESS completion: on the first cycle with waitrequest=0, readdata is captured, read/write deassert at the next edge, and the next state is RESP.
- Load extraction: select the lanes for the access, then sign-extend, or zero-extend when d_unsigned=1.
- Watchdog: when TIMEOUT>0 and waitrequest has been high for TIMEOUT consecutive ACCESS cycles, read/write deassert and the next state is RESP with err=1 and rdata=0.
- RESP: the owning channel's valid pulses for exactly one cycle, rdata is held valid in that cycle, and the next state is IDLE.
- Stores respond with rdata=0.
- Latency: minimum 3 cycles from accept to the next accept (accept, bus with waitrequest=0, respond), plus 1 cycle per waitrequest-high cycle.
- A non-accepted request must remain asserted by the core; the unit never buffers more than one request.

Decomposition:
- Shared package mips_bus_pkg holds: access-size enum (SZ_BYTE, SZ_HALF, SZ_WORD), FSM state enum, channel-id enum, and a misalignment helper function.
- Sub-module mips_lane_steer (combinational) implements store replication/byteenable generation and load lane selection/extension; it is parameterised by SWAP_BYTES.
- The top of the unit holds the FSM, arbiter and watchdog.

Test Plan:
- SWAP_BYTES=0 signed byte load: LB d_addr=0x00001001, readdata=0x11228344, waitrequest=0 → address=0x00001000, byteenable=4'b0010, d_rdata=0xFFFFFF83, d_valid 2 cycles after d_ready.
- SWAP_BYTES=1 unsigned byte load: same access with d_unsigned=1 → byteenable=4'b0100, d_rdata=0x00000022.
- Halfword store: SH d_addr=0x2002, d_wdata=0x0000ABCD, SWAP_BYTES=0 → writedata=0xABCDABCD, byteenable=4'b1100, write high for exactly 1 cycle, d_valid with d_err=0.
- Waitrequest hold: waitrequest high 3 cycles on an LW → read, address and byteenable stable for 4 cycles, if/d_valid exactly 1 cycle later, no second read.
- Arbitration and error paths:
  - ARB_MODE=1, if_req and d_req held continuously → grants alternate D, F, D, F.
  - ARB_MODE=0 → D wins every contention.
  - LW d_addr=0x1002 → d_err=1 one cycle after accept, read never asserted.
- Watchdog and reset:
  - TIMEOUT=8 with waitrequest stuck at 1 → read drops after 8 cycles, d_valid=1, d_err=1, d_rdata=0.
  - reset asserted mid-ACCESS → next cycle all outputs 0, no valid, busy=0.
